// File: rtl/aes_cipher_core.sv
// Iterative AES encryption core: one cipher round per clock over an externally
// supplied expanded key schedule, with valid/ready handshakes on both sides.
module aes_cipher_core #(
    parameter  int NK = 4,
    localparam int NR = NK + 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:127]             plaintext,
    input  logic [0:(4*(NR+1)*32)-1] Words,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:127]             ciphertext,
    output logic                     busy
);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_cipher_core: NK must be 4, 6 or 8");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm;
    logic [3:0]   round;
    logic [0:127] state_reg;
    logic [0:127] shifted;
    logic [0:127] round_key;
    logic [0:127] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: output byte (row, col) comes from column col+row.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(4*c+row) +: 8] = SBOX[s[8*(4*((c+row)%4)+row) +: 8]];
            end
        end
        return r;
    endfunction

    // 02/03/01/01 circulant, factored as a_i ^ (a0^a1^a2^a3) ^ xtime(a_i ^ a_i+1).
    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] m;
        logic [7:0]   a0, a1, a2, a3, t;
        m = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            t  = a0 ^ a1 ^ a2 ^ a3;
            m[32*c      +: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            m[32*c + 8  +: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            m[32*c + 16 +: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            m[32*c + 24 +: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return m;
    endfunction

    assign shifted   = sub_shift(state_reg);
    assign round_key = Words[{round, 7'd0} +: 128];
    assign round_out = ((round == LAST_ROUND) ? shifted : mix_columns(shifted)) ^ round_key;

    // NOTE: in_ready is combinational so DONE can retire and accept on the same edge.
    assign in_ready = rst_n && ((fsm == IDLE) || (fsm == DONE && out_ready));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            round      <= 4'd0;
            state_reg  <= '0;
            ciphertext <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= plaintext ^ Words[0:127];
                        round     <= 4'd1;
                        busy      <= 1'b1;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    if (round == LAST_ROUND) begin
                        ciphertext <= round_out;
                        out_valid  <= 1'b1;
                        busy       <= 1'b0;
                        fsm        <= DONE;
                    end else begin
                        state_reg <= round_out;
                        round     <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            state_reg <= plaintext ^ Words[0:127];
                            round     <= 4'd1;
                            busy      <= 1'b1;
                            fsm       <= ROUND;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
